// File: rtl/wb_spi_slave_if.sv
// Wishbone slave bus bundle for wb_spi_slave.
// Signals:
//   wb_adr_i  [31:0] address (only [3:2] decoded by the slave)
//   wb_dat_i  [31:0] write data
//   wb_dat_o  [31:0] read data, valid while wb_ack_o is high
//   wb_sel_i  [3:0]  byte select (ignored by the slave)
//   wb_stb_i, wb_cyc_i, wb_we_i  strobe, cycle, write enable
//   wb_ack_o         one-cycle acknowledge
// Modports: master drives the request side, slave drives dat_o/ack_o.
interface wb_spi_slave_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_spi_slave.sv
// SPI mode-0 slave (MSB first, 8-bit frames) with a Wishbone register port.
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-high reset
//   wb           Wishbone slave modport (see wb_spi_slave_if)
//   spi_sck      SPI clock from the external master (async to clk)
//   spi_ss_n     active-low slave select (async to clk)
//   spi_mosi     serial data in (async to clk)
//   spi_miso     serial data out, 0 while deselected
//   spi_miso_oe  MISO pad enable, synchronized ~spi_ss_n
//   intr         level interrupt: (rx_ie & rxne) | (tx_ie & txe)
// Register map (adr[3:2]): 0 RXDATA (read pops), 1 TXDATA (write),
//   2 STATUS {busy, ovr, txe, rxne} (write 1 to bit2 clears ovr),
//   3 CTRL {tx_ie, rx_ie}.
// Build option: define SPIS_RXFIFO_EN for a 4-entry RX FIFO; otherwise
//   the RX store is a single byte register.
// clk_freq is informational: SCK must stay at or below clk_freq/8.
//
// Bit engine states:
//   state | meaning
//   IDLE  | deselected, waiting for ss_n falling edge
//   LOAD  | one cycle: fetch TX byte (or 0xFF) into the shift register
//   SHIFT | sample MOSI on SCK rise, advance MISO on SCK fall
module wb_spi_slave #(
  parameter int unsigned clk_freq = 32'd100000000
) (
  input  logic          clk,
  input  logic          reset,
  wb_spi_slave_if.slave wb,
  input  logic          spi_sck,
  input  logic          spi_ss_n,
  input  logic          spi_mosi,
  output logic          spi_miso,
  output logic          spi_miso_oe,
  output logic          intr
);

  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, SHIFT = 2'd2} state_t;

  logic [31:0] unused_sck_max_hz;
  logic        unused_bits;
  assign unused_sck_max_hz = clk_freq / 32'd8;
  assign unused_bits = ^{wb.wb_sel_i, wb.wb_adr_i[31:4], wb.wb_adr_i[1:0],
                         wb.wb_dat_i[31:8]};

  // ---------------- synchronizers and edge detect ----------------
  logic [1:0] sck_sync, ss_sync, mosi_sync;
  logic       sck_q, ss_q;
  logic [1:0] sync_vld;
  logic       armed;
  logic       sck_s, ss_s, mosi_s;
  logic       sck_rise, sck_fall, ss_fall, ss_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync  <= 2'b00;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
      sck_q     <= 1'b0;
      ss_q      <= 1'b1;
      sync_vld  <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[0], spi_sck};
      ss_sync   <= {ss_sync[0], spi_ss_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_q     <= sck_sync[1];
      ss_q      <= ss_sync[1];
      sync_vld  <= {sync_vld[0], 1'b1};
      // The synchronizer resets to "deselected"; if ss_n is already low when
      // reset releases, that is not a real falling edge. Only accept falling
      // edges once ss_n has genuinely been seen high.
      if (sync_vld[1] && ss_sync[1]) armed <= 1'b1;
    end
  end

  assign sck_s    = sck_sync[1];
  assign ss_s     = ss_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign sck_rise = sck_s & ~sck_q;
  assign sck_fall = ~sck_s & sck_q;
  assign ss_fall  = ~ss_s & ss_q & armed;
  assign ss_rise  = ss_s & ~ss_q;

  assign spi_miso_oe = ~ss_s;

  // ---------------- bit engine ----------------
  state_t     state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_sr;
  logic [6:0] tx_sr;
  logic [7:0] tx_hold;
  logic       txe;
  logic [7:0] load_byte;
  logic       load_take;
  logic       push;
  logic [7:0] push_data;

  assign load_byte = txe ? 8'hFF : tx_hold;
  assign load_take = (state == LOAD) & ~ss_rise & ~txe;
  assign push      = (state == SHIFT) & ~ss_rise & sck_rise & (bit_cnt == 3'd7);
  assign push_data = {rx_sr, mosi_s};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bit_cnt  <= 3'd0;
      rx_sr    <= 7'd0;
      tx_sr    <= 7'd0;
      spi_miso <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bit_cnt  <= 3'd0;
          spi_miso <= 1'b0;
          if (ss_fall) state <= LOAD;
        end
        LOAD: begin
          if (ss_rise) begin
            state    <= IDLE;
            spi_miso <= 1'b0;
          end else begin
            tx_sr    <= load_byte[6:0];
            spi_miso <= load_byte[7];
            bit_cnt  <= 3'd0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (ss_rise) begin
            state    <= IDLE;
            bit_cnt  <= 3'd0;
            spi_miso <= 1'b0;
          end else if (sck_rise) begin
            rx_sr   <= {rx_sr[5:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= LOAD;
          end else if (sck_fall && bit_cnt != 3'd0) begin
            // bit_cnt==0 means no rising edge yet in this byte, so the
            // falling edge that trails the previous byte must not shift.
            tx_sr    <= {tx_sr[5:0], 1'b0};
            spi_miso <= tx_sr[6];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---------------- Wishbone decode ----------------
  logic        req, wr, rd;
  logic [1:0]  adr;
  logic        pop, wr_tx;
  logic        rxne, rx_full, push_ok, overrun;
  logic [7:0]  rx_head;
  logic        ovr;
  logic [1:0]  ctrl;
  logic        ack_q;
  logic [31:0] dat_q;
  logic [31:0] rd_data;

  assign req     = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign wr      = req & wb.wb_we_i;
  assign rd      = req & ~wb.wb_we_i;
  assign adr     = wb.wb_adr_i[3:2];
  assign pop     = rd & (adr == 2'd0) & rxne;
  assign wr_tx   = wr & (adr == 2'd1);
  // A pop in the same cycle frees a slot, so a push against a full store
  // is only an overrun when nothing is being read out.
  assign push_ok = push & (~rx_full | pop);
  assign overrun = push & rx_full & ~pop;

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;

  always_comb begin
    rd_data = 32'd0;
    case (adr)
      2'd0:    rd_data = {24'd0, rxne ? rx_head : 8'h00};
      2'd1:    rd_data = 32'd0;
      2'd2:    rd_data = {28'd0, ~ss_s, ovr, txe, rxne};
      default: rd_data = {30'd0, ctrl};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q   <= 1'b0;
      dat_q   <= 32'd0;
      tx_hold <= 8'd0;
      txe     <= 1'b1;
      ovr     <= 1'b0;
      ctrl    <= 2'd0;
    end else begin
      ack_q <= req;
      dat_q <= rd ? rd_data : 32'd0;
      // A write landing on the LOAD cycle wins txe: LOAD already took the
      // old byte, the new one stays pending.
      if (wr_tx) begin
        tx_hold <= wb.wb_dat_i[7:0];
        txe     <= 1'b0;
      end else if (load_take) begin
        txe <= 1'b1;
      end
      if (wr && adr == 2'd3) ctrl <= wb.wb_dat_i[1:0];
      if (overrun) ovr <= 1'b1;
      else if (wr && adr == 2'd2 && wb.wb_dat_i[2]) ovr <= 1'b0;
    end
  end

  // ---------------- RX store ----------------
`ifdef SPIS_RXFIFO_EN
  logic [7:0] fifo_mem [0:3];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] fifo_cnt;

  assign rxne    = (fifo_cnt != 3'd0);
  assign rx_full = (fifo_cnt == 3'd4);
  assign rx_head = fifo_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= 2'd0;
      rd_ptr   <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 2'd1;
      if (pop)     rd_ptr <= rd_ptr + 2'd1;
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  logic [7:0] rx_reg;
  logic       rx_valid;

  assign rxne    = rx_valid;
  assign rx_full = rx_valid;
  assign rx_head = rx_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_reg   <= 8'd0;
      rx_valid <= 1'b0;
    end else begin
      if (push_ok) rx_reg <= push_data;
      rx_valid <= push_ok | (rx_valid & ~pop);
    end
  end
`endif

  assign intr = (ctrl[0] & rxne) | (ctrl[1] & txe);

endmodule

// File: tb/tb_wb_spi_slave.sv
`timescale 1ns/1ps
module tb_wb_spi_slave;
  localparam int H = 8;  // SCK half period in clk cycles (SCK = clk/16)
`ifdef SPIS_RXFIFO_EN
  localparam int RX_DEPTH = 4;
`else
  localparam int RX_DEPTH = 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic spi_sck = 1'b0;
  logic spi_ss_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic spi_miso, spi_miso_oe, intr;

  wb_spi_slave_if wb ();

  wb_spi_slave #(.clk_freq(100000000)) dut (
    .clk(clk),
    .reset(reset),
    .wb(wb),
    .spi_sck(spi_sck),
    .spi_ss_n(spi_ss_n),
    .spi_mosi(spi_mosi),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .intr(intr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // behavioural model state for the randomized section
  logic [7:0] m_rxq[$];
  logic       m_txe;
  logic       m_ovr;
  logic [7:0] m_tx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] d,
                         output logic [31:0] q);
    logic got;
    got = 1'b0;
    q = 32'd0;
    @(negedge clk);
    wb.wb_adr_i = {28'd0, a, 2'b00};
    wb.wb_dat_i = d;
    wb.wb_we_i  = we;
    wb.wb_sel_i = 4'hF;
    wb.wb_stb_i = 1'b1;
    wb.wb_cyc_i = 1'b1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk);
      #1;
      if (wb.wb_ack_o) begin
        got = 1'b1;
        q = wb.wb_dat_o;
      end
    end
    wb.wb_stb_i = 1'b0;
    wb.wb_cyc_i = 1'b0;
    wb.wb_we_i  = 1'b0;
    if (!got) chk("wb_ack_timeout", {31'd0, got}, 32'd1);
  endtask

  task automatic wb_write(input logic [1:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic wb_read(input logic [1:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'd0, q);
  endtask

  task automatic ss_low();
    @(negedge clk);
    spi_ss_n = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic ss_high();
    @(negedge clk);
    spi_sck  = 1'b0;
    spi_ss_n = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  // Mode 0 master: MOSI set while SCK low, MISO sampled just before the rise.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'd0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_sck  = 1'b0;
      spi_mosi = tx[i];
      repeat (H) @(negedge clk);
      rx[i]   = spi_miso;
      spi_sck = 1'b1;
      repeat (H) @(negedge clk);
    end
    spi_sck = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  // one complete byte as the spec describes it: MISO gets the pending TX byte
  // or 0xFF, MOSI byte goes into the RX store unless it is full
  task automatic model_byte(input logic [7:0] mo, output logic [7:0] exp_miso);
    exp_miso = m_txe ? 8'hFF : m_tx;
    m_txe = 1'b1;
    if (m_rxq.size() < RX_DEPTH) m_rxq.push_back(mo);
    else m_ovr = 1'b1;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] q;
    logic [7:0]  r, e, mo, d;
    logic        seen;
    logic [7:0]  bytes [5];
    int          nb, nr;

    wb.wb_adr_i = 32'd0; wb.wb_dat_i = 32'd0; wb.wb_sel_i = 4'h0;
    wb.wb_stb_i = 1'b0;  wb.wb_cyc_i = 1'b0;  wb.wb_we_i  = 1'b0;
    bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78; bytes[4] = 8'h9A;

    // ---- reset values ----
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    chk("rst_dat", wb.wb_dat_o, 32'd0);
    chk("rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_intr", {31'd0, intr}, 32'd0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    wb_read(2'd2, q); chk("rst_status", q, 32'h2);
    wb_read(2'd3, q); chk("rst_ctrl", q, 32'h0);
    wb_read(2'd0, q); chk("empty_rx_read", q, 32'h0);
    wb_read(2'd2, q); chk("empty_rx_noside", q, 32'h2);

    // ---- basic exchange: TX 0xA5, master sends 0x3C ----
    wb_write(2'd1, 32'hA5);
    wb_read(2'd2, q); chk("txe_cleared", q, 32'h0);
    ss_low();
    chk("oe_selected", {31'd0, spi_miso_oe}, 32'd1);
    wb_read(2'd2, q); chk("busy_loaded", q, 32'hA);
    spi_bits(8'h3C, 8, r);
    chk("miso_a5", {24'd0, r}, 32'hA5);
    ss_high();
    chk("oe_deselected", {31'd0, spi_miso_oe}, 32'd0);
    chk("miso_idle", {31'd0, spi_miso}, 32'd0);
    wb_read(2'd2, q); chk("status_rxne", q, 32'h3);
    wb_read(2'd0, q); chk("rx_3c", q, 32'h3C);
    wb_read(2'd2, q); chk("status_after_pop", q, 32'h2);

    // ---- multi-byte frame: second MISO byte 0xFF, overrun past depth ----
    wb_write(2'd1, 32'h11);
    ss_low();
    for (int k = 0; k <= RX_DEPTH; k++) begin
      spi_bits(bytes[k], 8, r);
      chk("multi_miso", {24'd0, r}, (k == 0) ? 32'h11 : 32'hFF);
    end
    ss_high();
    wb_read(2'd2, q); chk("status_ovr", q, 32'h7);
    for (int k = 0; k < RX_DEPTH; k++) begin
      wb_read(2'd0, q); chk("ovr_rx_kept", q, {24'd0, bytes[k]});
    end
    wb_read(2'd0, q); chk("ovr_rx_drained", q, 32'h0);
    wb_read(2'd2, q); chk("status_ovr_empty", q, 32'h6);
    wb_write(2'd2, 32'h4);
    wb_read(2'd2, q); chk("ovr_cleared", q, 32'h2);

    // ---- partial byte aborted by ss_n, then full byte ----
    ss_low();
    spi_bits(8'hF0, 4, r);
    ss_high();
    ss_low();
    spi_bits(8'h81, 8, r);
    ss_high();
    wb_read(2'd2, q); chk("abort_status", q, 32'h3);
    wb_read(2'd0, q); chk("abort_rx_81", q, 32'h81);
    wb_read(2'd2, q); chk("abort_no_stray", q, 32'h2);

    // ---- interrupt timing ----
    wb_write(2'd3, 32'h1);
    chk("intr_idle", {31'd0, intr}, 32'd0);
    ss_low();
    spi_bits(8'h55, 7, r);
    spi_mosi = 1'b1;
    repeat (H) @(negedge clk);
    chk("intr_before_8th", {31'd0, intr}, 32'd0);
    spi_sck = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(posedge clk);
      #1;
      seen = intr;
    end
    chk("intr_within_4clk", {31'd0, seen}, 32'd1);
    @(negedge clk);
    repeat (H) @(negedge clk);
    spi_sck = 1'b0;
    repeat (H) @(negedge clk);
    ss_high();
    chk("intr_held", {31'd0, intr}, 32'd1);
    wb_read(2'd0, q);
    chk("intr_fall_on_ack", {31'd0, intr}, 32'd0);
    chk("intr_rx_55", q, 32'h55);
    wb_write(2'd3, 32'h2);
    chk("intr_tx_ie", {31'd0, intr}, 32'd1);
    wb_write(2'd1, 32'h77);
    chk("intr_tx_full", {31'd0, intr}, 32'd0);
    wb_write(2'd3, 32'h0);

    // ---- TX overwrite while pending ----
    wb_write(2'd1, 32'h01);
    wb_write(2'd1, 32'h02);
    ss_low();
    spi_bits(8'hE1, 8, r);
    ss_high();
    chk("tx_overwrite", {24'd0, r}, 32'h02);
    wb_read(2'd0, q); chk("rx_e1", q, 32'hE1);

    // ---- reset mid-frame ----
    wb_write(2'd3, 32'h3);
    chk("intr_pre_reset", {31'd0, intr}, 32'd1);
    ss_low();
    spi_bits(8'hE7, 3, r);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_ack", {31'd0, wb.wb_ack_o}, 32'd0);
    chk("mid_rst_dat", wb.wb_dat_o, 32'd0);
    chk("mid_rst_miso", {31'd0, spi_miso}, 32'd0);
    chk("mid_rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("mid_rst_intr", {31'd0, intr}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (H) @(negedge clk);
    spi_bits(8'h38, 5, r);
    ss_high();
    wb_read(2'd2, q); chk("post_rst_status", q, 32'h2);
    wb_read(2'd3, q); chk("post_rst_ctrl", q, 32'h0);
    wb_write(2'd1, 32'h96);
    ss_low();
    spi_bits(8'hC3, 8, r);
    ss_high();
    chk("post_rst_miso", {24'd0, r}, 32'h96);
    wb_read(2'd0, q); chk("post_rst_rx", q, 32'hC3);
    wb_read(2'd2, q); chk("post_rst_status2", q, 32'h2);

    // ---- randomized frames against the model ----
    m_rxq.delete();
    m_txe = 1'b1;
    m_ovr = 1'b0;
    m_tx  = 8'h00;
    for (int it = 0; it < 16; it++) begin
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom_range(0, 255));
        wb_write(2'd1, {24'd0, d});
        m_tx = d; m_txe = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          d = 8'($urandom_range(0, 255));
          wb_write(2'd1, {24'd0, d});
          m_tx = d;
        end
      end
      nb = int'($urandom_range(1, 3));
      ss_low();
      for (int b = 0; b < nb; b++) begin
        mo = 8'($urandom_range(0, 255));
        spi_bits(mo, 8, r);
        model_byte(mo, e);
        chk("rand_miso", {24'd0, r}, {24'd0, e});
      end
      ss_high();
      wb_read(2'd2, q);
      chk("rand_status", q, {29'd0, m_ovr, m_txe, m_rxq.size() != 0});
      nr = int'($urandom_range(0, 3));
      for (int k = 0; k < nr; k++) begin
        wb_read(2'd0, q);
        if (m_rxq.size() != 0) e = m_rxq.pop_front();
        else e = 8'h00;
        chk("rand_rx", q, {24'd0, e});
      end
      if (m_ovr && $urandom_range(0, 1) == 1) begin
        wb_write(2'd2, 32'h4);
        m_ovr = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_spi_slave.md
WB_SPI_SLAVE -- requirements
Module: wb_spi_slave

Interface
REQ-001 Parameter clk_freq, default 100000000: system clock frequency in Hz, informational; SCK limit derives from it.
REQ-002 clk  in  1  system clock; all state is clocked on its rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 wb_adr_i  in  32  Wishbone address; only bits [3:2] are decoded.
REQ-005 wb_dat_i  in  32  Wishbone write data.
REQ-006 wb_dat_o  out  32  Wishbone read data; unused bits read 0.
REQ-007 wb_sel_i  in  4  byte select; ignored, all accesses are treated as 32-bit.
REQ-008 wb_stb_i, wb_cyc_i, wb_we_i  in  1 each  Wishbone strobe, cycle and write enable.
REQ-009 wb_ack_o  out  1  Wishbone acknowledge.
REQ-010 spi_sck, spi_ss_n, spi_mosi  in  1 each  external SPI master clock, active-low select and data; asynchronous to clk.
REQ-011 spi_miso  out  1  serial data to the master.
REQ-012 spi_miso_oe  out  1  output enable for the MISO pad; equals synchronized ~spi_ss_n.
REQ-013 intr  out  1  level interrupt.

Function
REQ-014 Register map by adr[3:2]: 0 RXDATA (R, bits 7:0, read pops); 1 TXDATA (W, bits 7:0); 2 STATUS (R: bit0 rxne, bit1 txe, bit2 ovr, bit3 busy; W: write 1 to bit2 clears ovr); 3 CTRL (R/W: bit0 rx_ie, bit1 tx_ie).
REQ-015 wb_ack_o is a one-cycle pulse asserted the cycle after stb&cyc&~ack; the read/write side effect occurs on the ack cycle; wb_dat_o is valid while ack is high.
REQ-016 spi_sck, spi_ss_n and spi_mosi pass through 2-FF synchronizers; edges are detected on the synchronized signals.
REQ-017 SPI mode 0 only, MSB first, 8-bit frames; MOSI is sampled on the SCK rising edge and MISO changes on the SCK falling edge.
REQ-018 SCK frequency must not exceed clk_freq/8; behaviour above that limit is undefined.
REQ-019 Bit-engine states: IDLE (ss_n high) -> LOAD on ss_n falling -> SHIFT; after the 8th rising edge it returns to LOAD while ss_n stays low, and to IDLE on ss_n rising.
REQ-020 LOAD action: if txe=0, the TX holding byte moves to the shift register and txe becomes 1; otherwise 0xFF is loaded. MISO then presents bit 7 before the first rising edge.
REQ-021 On the 8th rising edge the received byte is pushed to the RX store and rxne becomes 1.
REQ-022 RX store full on push: the new byte is dropped, ovr becomes 1 and stored data is unchanged.
REQ-023 Pop and push in the same cycle: both take effect, no overrun, and rxne stays 1.
REQ-024 ss_n rising mid-byte: partial bits are discarded, the bit counter clears, and the shift register is discarded (TX byte is not restored).
REQ-025 TXDATA write while txe=0 overwrites the holding byte. Write and LOAD in the same cycle: LOAD takes the old byte, the new byte is held, and txe=0.
REQ-026 busy = ~ss_n synchronized; spi_miso = 0 whenever ss_n is high.
REQ-027 intr = (rx_ie & rxne) | (tx_ie & txe).
REQ-028 RXDATA read while empty returns 0 and has no side effect.

Reset
REQ-029 Reset values: wb_ack_o=0, wb_dat_o=0, spi_miso=0, spi_miso_oe=0, intr=0, rxne=0, txe=1, ovr=0, CTRL=0, bit counter=0, synchronizers=idle (ss_n=1, sck=0).
REQ-030 Reset asserted mid-frame aborts the frame. After release, the engine waits for the next ss_n falling edge; the remaining bits of the aborted frame are ignored.

Configuration
REQ-031 SPIS_RXFIFO_EN defined: the RX store is a 4-entry FIFO, rxne = not empty, and the full condition is 4 entries.
REQ-032 SPIS_RXFIFO_EN undefined: the RX store is a single byte register, and the full condition is rxne=1.

Verification
REQ-033 Write TXDATA=0xA5; master sends 0x3C on MOSI -> MISO bits 10100101; RXDATA reads 0x3C; rxne then 0; txe=1.
REQ-034 Two-byte frame with no TX write after the first byte -> the second MISO byte is 0xFF.
REQ-035 Master sends 2 bytes without CPU reads (FIFO off) -> ovr=1 and RXDATA returns the first byte. Same test with 5 bytes (FIFO on) -> first 4 bytes read back and ovr=1. Writing STATUS=0x4 clears ovr.
REQ-036 ss_n deasserted after 4 bits of 0xF0, then full byte 0x81 -> RXDATA=0x81 only, with no stray entry.
REQ-037 CTRL=0x1; byte 0x55 received -> intr rises within 4 clk of the 8th SCK edge and falls on the ack of the RXDATA read.
REQ-038 Reset pulsed after bit 3 of a frame -> all REQ-029 values hold; the next complete frame after ss_n toggles is received correctly.
